// File: rtl/bp_update_if.sv
// Handshake bundle between commit, the branch update unit and fetch/PHT.
// Ports (by modport):
//   master : commit/fetch side; drives resolve_* and upd_ready, observes the rest.
//   slave  : update unit; accepts resolve_*, drives upd_*, redirect_* and counters.
interface bp_update_if #(
  parameter int unsigned IDX_W = 6,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 16
);
  logic             resolve_valid;
  logic             resolve_ready;
  logic [PC_W-1:0]  resolve_pc;
  logic             resolve_taken;
  logic             resolve_pred;
  logic [PC_W-1:0]  resolve_target;

  logic             upd_valid;
  logic             upd_ready;
  logic [IDX_W-1:0] upd_index;
  logic             upd_taken;

  logic             redirect_valid;
  logic [PC_W-1:0]  redirect_pc;

  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  modport master (
    output resolve_valid, resolve_pc, resolve_taken, resolve_pred, resolve_target, upd_ready,
    input  resolve_ready, upd_valid, upd_index, upd_taken, redirect_valid, redirect_pc,
    input  branch_count, mispredict_count
  );

  modport slave (
    input  resolve_valid, resolve_pc, resolve_taken, resolve_pred, resolve_target, upd_ready,
    output resolve_ready, upd_valid, upd_index, upd_taken, redirect_valid, redirect_pc,
    output branch_count, mispredict_count
  );
endinterface

// File: rtl/bp_update_unit.sv
// Branch predictor update unit.
// Buffers resolved conditional branches from commit in an in-order FIFO, drains
// one {index, taken} update per cycle to the pattern history table, raises a
// one-cycle fetch redirect on mispredict at acceptance, and keeps saturating
// branch / mispredict counters.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high; clears FIFO, redirect and counters
//   bus   : bp_update_if slave modport (resolve_*, upd_*, redirect_*, counters)
module bp_update_unit #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = 6,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 16
) (
  input logic        clk,
  input logic        reset,
  bp_update_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] PERF_ONE  = CNT_W'(1);
  localparam logic [PC_W-1:0]  PC_FOUR   = PC_W'(4);

  // Each entry is {index, taken}.
  logic [IDX_W:0]   mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [PTR_W:0]   count_q;
  logic             redirect_valid_q;
  logic [PC_W-1:0]  redirect_pc_q;
  logic [CNT_W-1:0] branch_count_q, mispredict_count_q;

  logic             full, push, pop, mis;
  logic [IDX_W-1:0] push_index;
  logic [PC_W-1:0]  correct_pc;

  // Full is a registered-state decode only; a same-cycle pop does not relieve it.
  assign full       = (count_q == DEPTH_CNT);
  assign push       = bus.resolve_valid && !full;
  assign pop        = (count_q != '0) && bus.upd_ready;
  assign mis        = bus.resolve_taken != bus.resolve_pred;
  assign push_index = bus.resolve_pc[IDX_W+1:2];
  assign correct_pc = bus.resolve_taken ? bus.resolve_target : bus.resolve_pc + PC_FOUR;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      head_q             <= '0;
      tail_q             <= '0;
      count_q            <= '0;
      redirect_valid_q   <= 1'b0;
      redirect_pc_q      <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      if (push) begin
        mem_q[tail_q] <= {push_index, bus.resolve_taken};
        tail_q        <= tail_q + PTR_ONE;
      end
      if (pop) begin
        head_q <= head_q + PTR_ONE;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase

      // Pulse lasts exactly one cycle per mispredicting push; PC held otherwise.
      redirect_valid_q <= push && mis;
      if (push && mis) begin
        redirect_pc_q <= correct_pc;
      end

      if (push && (branch_count_q != '1)) begin
        branch_count_q <= branch_count_q + PERF_ONE;
      end
      if (push && mis && (mispredict_count_q != '1)) begin
        mispredict_count_q <= mispredict_count_q + PERF_ONE;
      end
    end
  end

  assign bus.resolve_ready    = !full;
  assign bus.upd_valid        = (count_q != '0);
  assign bus.upd_index        = mem_q[head_q][IDX_W:1];
  assign bus.upd_taken        = mem_q[head_q][0];
  assign bus.redirect_valid   = redirect_valid_q;
  assign bus.redirect_pc      = redirect_pc_q;
  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_bp_update_unit.sv
// Directed self-checking bench for bp_update_unit.
module tb_bp_update_unit;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  bp_update_if #(.IDX_W(6), .PC_W(32), .CNT_W(16)) bus ();

  bp_update_unit #(.DEPTH(4), .IDX_W(6), .PC_W(32), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic t, input logic p,
                       input logic [31:0] tgt);
    bus.resolve_valid  = v;
    bus.resolve_pc     = pc;
    bus.resolve_taken  = t;
    bus.resolve_pred   = p;
    bus.resolve_target = tgt;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.upd_ready = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_ready", {31'b0, bus.resolve_ready}, 32'd1);
    chk("rst_upd_valid", {31'b0, bus.upd_valid}, 32'd0);
    chk("rst_redir_valid", {31'b0, bus.redirect_valid}, 32'd0);
    chk("rst_redir_pc", bus.redirect_pc, 32'h0);
    chk("rst_bcount", {16'b0, bus.branch_count}, 32'd0);
    chk("rst_mcount", {16'b0, bus.mispredict_count}, 32'd0);

    // Single correctly predicted branch, visible the cycle after the push
    drive(1'b1, 32'h10, 1'b1, 1'b1, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("t1_upd_valid", {31'b0, bus.upd_valid}, 32'd1);
    chk("t1_upd_index", {26'b0, bus.upd_index}, 32'd4);
    chk("t1_upd_taken", {31'b0, bus.upd_taken}, 32'd1);
    chk("t1_redir", {31'b0, bus.redirect_valid}, 32'd0);
    tick();
    chk("t1_drained", {31'b0, bus.upd_valid}, 32'd0);
    chk("t1_bcount", {16'b0, bus.branch_count}, 32'd1);

    // Back-to-back mispredicts
    drive(1'b1, 32'h100, 1'b1, 1'b0, 32'h200);
    tick();
    chk("m1_redir", {31'b0, bus.redirect_valid}, 32'd1);
    chk("m1_pc", bus.redirect_pc, 32'h200);
    drive(1'b1, 32'h104, 1'b0, 1'b1, 32'h300);
    tick();
    chk("m2_redir", {31'b0, bus.redirect_valid}, 32'd1);
    chk("m2_pc", bus.redirect_pc, 32'h108);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("m_redir_low", {31'b0, bus.redirect_valid}, 32'd0);
    chk("m_pc_hold", bus.redirect_pc, 32'h108);
    chk("m_mcount", {16'b0, bus.mispredict_count}, 32'd2);
    chk("m_bcount", {16'b0, bus.branch_count}, 32'd3);
    chk("m_empty", {31'b0, bus.upd_valid}, 32'd0);

    // Fill with PHT stalled; fifth (a mispredict) must be ignored entirely
    bus.upd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) drive(1'b1, 32'h30, 1'b1, 1'b0, 32'h900);
      else        drive(1'b1, 32'h20 + 32'(4 * i), ~i[0], ~i[0], 32'h0);
      tick();
      chk("fill_hold_index", {26'b0, bus.upd_index}, 32'd8);
      chk("fill_hold_taken", {31'b0, bus.upd_taken}, 32'd1);
      if (i >= 3) chk("fill_ready", {31'b0, bus.resolve_ready}, 32'd0);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("full_no_redir", {31'b0, bus.redirect_valid}, 32'd0);
    chk("full_bcount", {16'b0, bus.branch_count}, 32'd7);
    chk("full_mcount", {16'b0, bus.mispredict_count}, 32'd2);
    bus.upd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", {31'b0, bus.upd_valid}, 32'd1);
      chk("drain_index", {26'b0, bus.upd_index}, 32'(8 + i));
      chk("drain_taken", {31'b0, bus.upd_taken}, {31'b0, ~i[0]});
      tick();
    end
    chk("drain_done", {31'b0, bus.upd_valid}, 32'd0);

    // Steady state at count 2: push and pop every cycle, pointers wrap
    bus.upd_ready = 1'b0;
    drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b1, 32'h44, 1'b1, 1'b1, 32'h0);
    tick();
    bus.upd_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'h48 + 32'(4 * k), 1'b0, 1'b0, 32'h0);
      chk("ss_valid", {31'b0, bus.upd_valid}, 32'd1);
      chk("ss_index", {26'b0, bus.upd_index}, 32'(16 + k));
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("ss_tail0", {26'b0, bus.upd_index}, 32'd26);
    tick();
    chk("ss_tail1", {26'b0, bus.upd_index}, 32'd27);
    tick();
    chk("ss_empty", {31'b0, bus.upd_valid}, 32'd0);
    chk("ss_bcount", {16'b0, bus.branch_count}, 32'd19);

    // Saturation of branch_count
    drive(1'b1, 32'h80, 1'b1, 1'b1, 32'h0);
    for (int n = 0; n < 32'hFFFE - 19; n++) tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("sat_fffe", {16'b0, bus.branch_count}, 32'hFFFE);
    drive(1'b1, 32'h80, 1'b1, 1'b1, 32'h0);
    for (int n = 0; n < 3; n++) tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("sat_ffff", {16'b0, bus.branch_count}, 32'hFFFF);
    chk("sat_mcount", {16'b0, bus.mispredict_count}, 32'd2);

    // Asynchronous reset mid-cycle with entries queued and a redirect pending
    bus.upd_ready = 1'b0;
    drive(1'b1, 32'h50, 1'b1, 1'b1, 32'h0);
    tick();
    drive(1'b1, 32'h54, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b1, 32'h58, 1'b1, 1'b0, 32'h500);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("pre_rst_redir", {31'b0, bus.redirect_valid}, 32'd1);
    chk("pre_rst_pc", bus.redirect_pc, 32'h500);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_upd_valid", {31'b0, bus.upd_valid}, 32'd0);
    chk("arst_redir", {31'b0, bus.redirect_valid}, 32'd0);
    chk("arst_pc", bus.redirect_pc, 32'h0);
    chk("arst_bcount", {16'b0, bus.branch_count}, 32'd0);
    chk("arst_mcount", {16'b0, bus.mispredict_count}, 32'd0);
    chk("arst_ready", {31'b0, bus.resolve_ready}, 32'd1);
    tick();
    reset = 1'b0;
    bus.upd_ready = 1'b1;
    tick();
    chk("post_rst_valid", {31'b0, bus.upd_valid}, 32'd0);
    chk("post_rst_ready", {31'b0, bus.resolve_ready}, 32'd1);
    drive(1'b1, 32'hFC, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("post_rst_index", {26'b0, bus.upd_index}, 32'd63);
    chk("post_rst_taken", {31'b0, bus.upd_taken}, 32'd0);
    tick();
    chk("post_rst_empty", {31'b0, bus.upd_valid}, 32'd0);
    chk("post_rst_bcount", {16'b0, bus.branch_count}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
